// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream, writes the payload
// into instruction memory in stream order, verifies an 8-bit additive
// checksum and holds the CPU pipeline in reset until a load completes cleanly.
//
// Stream format: LEN_HI, LEN_LO, <len payload bytes>, CHECKSUM.
// Payload byte n is written to address n; the checksum byte must equal the
// modulo-256 sum of the payload bytes (0x00 when len is zero).

module imem_loader #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // The byte counter needs one bit more than the address so it can reach DEPTH.
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [15:0] DEPTH_LEN = 16'(DEPTH);

    state_t          state;
    state_t          state_next;

    logic [15:0]     len_q;
    logic [AW:0]     cnt_q;
    logic [7:0]      sum_q;

    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [7:0]      wdata_q;

    logic            xfer;
    logic [15:0]     len_full;
    logic            last_byte;

    // A byte moves only on a valid/ready handshake.
    assign xfer = in_valid && in_ready;

    // Length as it will be once the low byte currently on in_data is captured.
    assign len_full = {len_q[15:8], in_data};

    // The byte being accepted in DATA is the final payload byte.
    assign last_byte = ((16'(cnt_q) + 16'd1) == len_q);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE, DONE and ERROR.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) begin
                    if (len_full == 16'd0)        state_next = CHECK;
                    else if (len_full > DEPTH_LEN) state_next = ERROR;
                    else                          state_next = DATA;
                end
            end
            DATA: begin
                if (xfer && last_byte) state_next = CHECK;
            end
            CHECK: begin
                if (xfer) begin
                    if (in_data == sum_q) state_next = DONE;
                    else                  state_next = ERROR;
                end
            end
            DONE: begin
                if (start) state_next = LEN_HI;
            end
            ERROR: begin
                if (start) state_next = LEN_HI;
            end
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        case (state)
            LEN_HI, LEN_LO, DATA, CHECK: in_ready = 1'b1;
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERROR: error = 1'b1;
            default: ;
        endcase
    end

    // Length capture, payload counter/checksum and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (state_next == LEN_HI && state != LEN_HI) begin
                cnt_q <= '0;
                sum_q <= '0;
            end
            if (xfer) begin
                case (state)
                    LEN_HI: len_q[15:8] <= in_data;
                    LEN_LO: len_q[7:0]  <= in_data;
                    DATA: begin
                        we_q    <= 1'b1;
                        addr_q  <= cnt_q[AW-1:0];
                        wdata_q <= in_data;
                        cnt_q   <= cnt_q + CNT_ONE;
                        sum_q   <= sum_q + in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The strobe is registered from the accepting edge; reset masks it at once
    // so a write already in flight when reset arrives never reaches memory.
    assign mem_we    = we_q && !reset;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven check of imem_loader sessions plus directed
// sequences for reset, start filtering and a long stalled full-depth load.

module tb_imem_loader;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Write monitor: records every strobe seen between clock edges.
    logic [AW-1:0] wq_addr[$];
    logic [7:0]    wq_data[$];
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
    end

    typedef struct {
        string        name;
        int           nb;
        logic [127:0] bytes;   // right-aligned, first stream byte most significant
        logic         exp_done;
        logic         exp_err;
        int           exp_wr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int stall);
        int n;
        repeat (stall) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
    endtask

    task automatic idle_bus(input int cycles);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_hold_after_start"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_ready_after_start"}, 32'(in_ready), 32'd1);
        chk({tag, "_done_clear"}, 32'(done), 32'd0);
        chk({tag, "_error_clear"}, 32'(error), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    // Normal 8-byte program: 20 01 00 05 00 00 00 00, checksum 0x26.
    task automatic send_normal(input int stop_after, input logic start_mid);
        logic [7:0] prog [0:10];
        prog = '{8'h00, 8'h08, 8'h20, 8'h01, 8'h00, 8'h05,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h26};
        for (int i = 0; i < 11 && i < stop_after; i++) begin
            if (start_mid && i == 5) begin
                @(negedge clk);
                in_valid = 1'b0;
                start    = 1'b1;
                @(negedge clk);
                start    = 1'b0;
            end
            send(prog[i], 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nerr;
        logic [7:0] s;
        logic [7:0] d;

        vecs[0] = '{"normal",   11, 128'h0008_2001_0005_0000_0000_26, 1'b1, 1'b0, 8};
        vecs[1] = '{"badsum",   11, 128'h0008_2001_0005_0000_0000_27, 1'b0, 1'b1, 8};
        vecs[2] = '{"oversize",  2, 128'h0201,                        1'b0, 1'b1, 0};
        vecs[3] = '{"zero_ok",   3, 128'h00_0000,                     1'b1, 1'b0, 0};
        vecs[4] = '{"zero_bad",  3, 128'h00_0001,                     1'b0, 1'b1, 0};
        vecs[5] = '{"sumwrap",   6, 128'h0003_FF01_0202,              1'b1, 1'b0, 3};
        vecs[6] = '{"len_ffff",  2, 128'hFFFF,                        1'b0, 1'b1, 0};
        vecs[7] = '{"len_one",   4, 128'h0001_A5A5,                   1'b1, 1'b0, 1};

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_hold", 32'(cpu_hold), 32'd1);

        // Table-driven sessions; each one starts from the previous end state.
        for (int k = 0; k < 8; k++) begin
            pulse_start(vecs[k].name);
            wq_addr.delete();
            wq_data.delete();
            for (int i = 0; i < vecs[k].nb; i++)
                send(vecs[k].bytes[8*(vecs[k].nb-1-i) +: 8], (i % 3 == 1) ? 2 : 0);
            idle_bus(3);
            chk({vecs[k].name, "_done"}, 32'(done), 32'(vecs[k].exp_done));
            chk({vecs[k].name, "_error"}, 32'(error), 32'(vecs[k].exp_err));
            chk({vecs[k].name, "_hold"}, 32'(cpu_hold), 32'(!vecs[k].exp_done));
            chk({vecs[k].name, "_ready"}, 32'(in_ready), 32'd0);
            chk({vecs[k].name, "_nwrites"}, 32'(wq_addr.size()), 32'(vecs[k].exp_wr));
            nerr = 0;
            for (int i = 0; i < vecs[k].exp_wr && i < wq_addr.size(); i++) begin
                if (wq_addr[i] !== AW'(i)) nerr++;
                if (wq_data[i] !== vecs[k].bytes[8*(vecs[k].nb-3-i) +: 8]) nerr++;
            end
            chk({vecs[k].name, "_write_content"}, 32'(nerr), 32'd0);
        end

        // Start during DATA must be ignored; the session still completes.
        pulse_start("midstart");
        wq_addr.delete();
        wq_data.delete();
        send_normal(11, 1'b1);
        idle_bus(3);
        chk("midstart_done", 32'(done), 32'd1);
        chk("midstart_nwrites", 32'(wq_addr.size()), 32'd8);

        // Reset after 3 of 8 payload bytes aborts the session.
        pulse_start("midreset");
        send_normal(5, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk_reset_vals("midreset");
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_idle_ready", 32'(in_ready), 32'd0);
        pulse_start("after_reset");
        wq_addr.delete();
        wq_data.delete();
        send_normal(11, 1'b0);
        idle_bus(3);
        chk("after_reset_done", 32'(done), 32'd1);
        chk("after_reset_nwrites", 32'(wq_addr.size()), 32'd8);
        nerr = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] !== AW'(i)) nerr++;
        chk("after_reset_addr_order", 32'(nerr), 32'd0);
        chk("after_reset_byte5", 32'(wq_data[3]), 32'h05);

        // Reset and start together: reset wins, loader stays idle.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_ready", 32'(in_ready), 32'd0);
        chk("rst_start_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("rst_start_still_idle", 32'(in_ready), 32'd0);

        // Full-depth load with random stalls.
        pulse_start("big");
        wq_addr.delete();
        wq_data.delete();
        send(8'h02, $urandom_range(0, 2));
        send(8'h00, $urandom_range(0, 2));
        s = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(i * 13 + 5);
            s = s + d;
            send(d, $urandom_range(0, 2));
        end
        send(s, $urandom_range(0, 3));
        idle_bus(3);
        chk("big_done", 32'(done), 32'd1);
        chk("big_error", 32'(error), 32'd0);
        chk("big_nwrites", 32'(wq_addr.size()), 32'(DEPTH));
        nerr = 0;
        for (int i = 0; i < wq_addr.size() && i < DEPTH; i++) begin
            if (wq_addr[i] !== AW'(i)) nerr++;
            if (wq_data[i] !== 8'(i * 13 + 5)) nerr++;
        end
        chk("big_write_content", 32'(nerr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
